// File: rtl/rv_ctrl_pkg.sv
// Shared constants, state/class enums and decode helpers for the multicycle RV32I-subset controller.
package rv_ctrl_pkg;

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I      = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;

    localparam logic [2:0] IMM_I = 3'd0;
    localparam logic [2:0] IMM_S = 3'd1;
    localparam logic [2:0] IMM_B = 3'd2;
    localparam logic [2:0] IMM_U = 3'd3;
    localparam logic [2:0] IMM_J = 3'd4;

    localparam logic [1:0] ALU_ADD   = 2'd0;
    localparam logic [1:0] ALU_SUB   = 2'd1;
    localparam logic [1:0] ALU_FUNCT = 2'd2;

    localparam logic [1:0] WB_ALU = 2'd0;
    localparam logic [1:0] WB_MEM = 2'd1;
    localparam logic [1:0] WB_PC4 = 2'd2;
    localparam logic [1:0] WB_IMM = 2'd3;

    localparam logic [1:0] PC_PLUS4  = 2'd0;
    localparam logic [1:0] PC_TARGET = 2'd1;

    localparam logic [2:0] F3_BEQ = 3'b000;
    localparam logic [2:0] F3_BNE = 3'b001;

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_DECODE,
        S_EXEC,
        S_MEM_RD,
        S_MEM_WR,
        S_WB,
        S_TRAP
    } state_e;

    typedef enum logic [2:0] {
        C_R,
        C_I,
        C_LOAD,
        C_STORE,
        C_BRANCH,
        C_JAL,
        C_LUI,
        C_BAD
    } cls_e;

    function automatic cls_e decode_class(input logic [6:0] op);
        cls_e c;
        case (op)
            OP_R:      c = C_R;
            OP_I:      c = C_I;
            OP_LOAD:   c = C_LOAD;
            OP_STORE:  c = C_STORE;
            OP_BRANCH: c = C_BRANCH;
            OP_JAL:    c = C_JAL;
            OP_LUI:    c = C_LUI;
            default:   c = C_BAD;
        endcase
        return c;
    endfunction

    // R-type has no immediate; IMM_I is driven there as an unused default.
    function automatic logic [2:0] imm_for_class(input cls_e c);
        logic [2:0] s;
        case (c)
            C_STORE:  s = IMM_S;
            C_BRANCH: s = IMM_B;
            C_JAL:    s = IMM_J;
            C_LUI:    s = IMM_U;
            default:  s = IMM_I;
        endcase
        return s;
    endfunction

endpackage

// File: rtl/multicycle_ctrl_mem_timeout_cnt.sv
// Wait-cycle counter for one memory request; expired flags the last allowed waiting cycle.
module mem_timeout_cnt #(
    parameter int MEM_TIMEOUT = 16
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic en,
    output logic expired
);

    localparam int CNT_W = $clog2(MEM_TIMEOUT + 1);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(MEM_TIMEOUT - 1);

    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (en && !expired) begin
            cnt <= cnt + 1'b1;
        end
    end

    // Count value k is seen during waiting cycle k+1, so LAST marks the MEM_TIMEOUT-th wait.
    assign expired = (cnt == LAST);

endmodule

// File: rtl/multicycle_ctrl.sv
// Multicycle control FSM for a shared RV32I-subset datapath; one datapath phase per state.
// Optional MULTICYCLE_CTRL_PERF_EN adds cycle_cnt_o / instret_o performance counters.
//
//  state    | meaning
//  ---------+---------------------------------------------------------------
//  IDLE     | halted, waits for start_i
//  FETCH    | instruction read at PC; on ready latch IR and PC <= PC+4
//  DECODE   | classify opcode, select immediate format
//  EXEC     | drive ALU; branches resolve here, JAL writes PC
//  MEM_RD   | load data read at ALU result address
//  MEM_WR   | store data write at ALU result address
//  WB       | single-cycle register file write
//  TRAP     | illegal opcode/funct3 or memory timeout; left only by reset
module multicycle_ctrl
    import rv_ctrl_pkg::*;
#(
    parameter int MEM_TIMEOUT = 16
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       start_i,
    input  logic [6:0] opcode_i,
    input  logic [2:0] funct3_i,
    input  logic       zero_i,
    input  logic       mem_ready_i,
    output logic       mem_req_o,
    output logic       mem_we_o,
    output logic       mem_addr_sel_o,
    output logic       ir_we_o,
    output logic       pc_we_o,
    output logic [1:0] pc_src_o,
    output logic [2:0] imm_sel_o,
    output logic       alu_src_b_o,
    output logic [1:0] alu_op_o,
    output logic       reg_we_o,
    output logic [1:0] wb_sel_o,
    output logic       busy_o,
    output logic       illegal_o
`ifdef MULTICYCLE_CTRL_PERF_EN
    ,
    output logic [31:0] cycle_cnt_o,
    output logic [31:0] instret_o
`endif
);

    state_e state, state_next;
    cls_e   cls, cls_next;
    cls_e   decoded;
    state_e boundary_state;
    logic   branch_taken;
    logic   tmo_clr, tmo_en, tmo_expired;
    logic   illegal_q;

    assign decoded        = decode_class(opcode_i);
    assign boundary_state = start_i ? S_FETCH : S_IDLE;
    assign branch_taken   = (funct3_i == F3_BEQ) ? zero_i : !zero_i;

    // Any state change restarts the wait count, so each request state starts from zero.
    assign tmo_clr = (state_next != state);
    assign tmo_en  = mem_req_o && !mem_ready_i;

    mem_timeout_cnt #(
        .MEM_TIMEOUT(MEM_TIMEOUT)
    ) u_tmo (
        .clk    (clk_i),
        .rst_n  (rst_i),
        .clr    (tmo_clr),
        .en     (tmo_en),
        .expired(tmo_expired)
    );

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state     <= S_IDLE;
            cls       <= C_R;
            illegal_q <= 1'b0;
        end else begin
            state <= state_next;
            cls   <= cls_next;
            if (state_next == S_TRAP) begin
                illegal_q <= 1'b1;
            end
        end
    end

    always_comb begin
        state_next     = state;
        cls_next       = cls;
        mem_req_o      = 1'b0;
        mem_we_o       = 1'b0;
        mem_addr_sel_o = 1'b0;
        ir_we_o        = 1'b0;
        pc_we_o        = 1'b0;
        pc_src_o       = PC_PLUS4;
        imm_sel_o      = IMM_I;
        alu_src_b_o    = 1'b0;
        alu_op_o       = ALU_ADD;
        reg_we_o       = 1'b0;
        wb_sel_o       = WB_ALU;

        case (state)
            S_IDLE: begin
                if (start_i) begin
                    state_next = S_FETCH;
                end
            end

            S_FETCH: begin
                mem_req_o = 1'b1;
                if (mem_ready_i) begin
                    ir_we_o    = 1'b1;
                    pc_we_o    = 1'b1;
                    state_next = S_DECODE;
                end else if (tmo_expired) begin
                    state_next = S_TRAP;
                end
            end

            S_DECODE: begin
                imm_sel_o  = imm_for_class(decoded);
                cls_next   = decoded;
                state_next = (decoded == C_BAD) ? S_TRAP : S_EXEC;
            end

            S_EXEC: begin
                imm_sel_o = imm_for_class(cls);
                case (cls)
                    C_R: begin
                        alu_op_o   = ALU_FUNCT;
                        state_next = S_WB;
                    end
                    C_I: begin
                        alu_op_o    = ALU_FUNCT;
                        alu_src_b_o = 1'b1;
                        state_next  = S_WB;
                    end
                    C_LOAD: begin
                        alu_src_b_o = 1'b1;
                        state_next  = S_MEM_RD;
                    end
                    C_STORE: begin
                        alu_src_b_o = 1'b1;
                        state_next  = S_MEM_WR;
                    end
                    C_BRANCH: begin
                        alu_op_o = ALU_SUB;
                        if (funct3_i == F3_BEQ || funct3_i == F3_BNE) begin
                            if (branch_taken) begin
                                pc_we_o  = 1'b1;
                                pc_src_o = PC_TARGET;
                            end
                            state_next = boundary_state;
                        end else begin
                            state_next = S_TRAP;
                        end
                    end
                    C_JAL: begin
                        pc_we_o    = 1'b1;
                        pc_src_o   = PC_TARGET;
                        state_next = S_WB;
                    end
                    C_LUI: begin
                        state_next = S_WB;
                    end
                    default: begin
                        state_next = S_TRAP;
                    end
                endcase
            end

            S_MEM_RD: begin
                mem_req_o      = 1'b1;
                mem_addr_sel_o = 1'b1;
                imm_sel_o      = imm_for_class(cls);
                if (mem_ready_i) begin
                    state_next = S_WB;
                end else if (tmo_expired) begin
                    state_next = S_TRAP;
                end
            end

            S_MEM_WR: begin
                mem_req_o      = 1'b1;
                mem_we_o       = 1'b1;
                mem_addr_sel_o = 1'b1;
                imm_sel_o      = imm_for_class(cls);
                if (mem_ready_i) begin
                    state_next = boundary_state;
                end else if (tmo_expired) begin
                    state_next = S_TRAP;
                end
            end

            S_WB: begin
                reg_we_o  = 1'b1;
                imm_sel_o = imm_for_class(cls);
                case (cls)
                    C_LOAD:  wb_sel_o = WB_MEM;
                    C_JAL:   wb_sel_o = WB_PC4;
                    C_LUI:   wb_sel_o = WB_IMM;
                    default: wb_sel_o = WB_ALU;
                endcase
                state_next = boundary_state;
            end

            S_TRAP: begin
                state_next = S_TRAP;
            end

            default: begin
                state_next = S_IDLE;
            end
        endcase
    end

    assign busy_o    = (state != S_IDLE) && (state != S_TRAP);
    assign illegal_o = illegal_q;

`ifdef MULTICYCLE_CTRL_PERF_EN
    logic instr_done;

    // An instruction retires when its last state hands back to FETCH or IDLE.
    assign instr_done = ((state_next == S_FETCH) || (state_next == S_IDLE)) &&
                        ((state == S_EXEC) || (state == S_WB) || (state == S_MEM_WR));

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            cycle_cnt_o <= '0;
            instret_o   <= '0;
        end else begin
            if (busy_o) begin
                cycle_cnt_o <= cycle_cnt_o + 32'd1;
            end
            if (instr_done) begin
                instret_o <= instret_o + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Self-checking bench for multicycle_ctrl: table-driven instruction vectors through a scoreboard plus corner sequences.
module tb_multicycle_ctrl;

    localparam logic [6:0] T_OP_R      = 7'h33;
    localparam logic [6:0] T_OP_I      = 7'h13;
    localparam logic [6:0] T_OP_LOAD   = 7'h03;
    localparam logic [6:0] T_OP_STORE  = 7'h23;
    localparam logic [6:0] T_OP_BRANCH = 7'h63;
    localparam logic [6:0] T_OP_JAL    = 7'h6F;
    localparam logic [6:0] T_OP_LUI    = 7'h37;
    localparam logic [6:0] T_OP_BAD    = 7'h7F;
    localparam int NEVER = 1000;

    logic       clk_i, rst_i, start_i, zero_i, mem_ready_i;
    logic [6:0] opcode_i;
    logic [2:0] funct3_i;
    logic       mem_req_o, mem_we_o, mem_addr_sel_o, ir_we_o, pc_we_o;
    logic [1:0] pc_src_o, alu_op_o, wb_sel_o;
    logic [2:0] imm_sel_o;
    logic       alu_src_b_o, reg_we_o, busy_o, illegal_o;
`ifdef MULTICYCLE_CTRL_PERF_EN
    logic [31:0] cycle_cnt_o, instret_o;
`endif

    multicycle_ctrl #(.MEM_TIMEOUT(16)) dut (
        .clk_i         (clk_i),
        .rst_i         (rst_i),
        .start_i       (start_i),
        .opcode_i      (opcode_i),
        .funct3_i      (funct3_i),
        .zero_i        (zero_i),
        .mem_ready_i   (mem_ready_i),
        .mem_req_o     (mem_req_o),
        .mem_we_o      (mem_we_o),
        .mem_addr_sel_o(mem_addr_sel_o),
        .ir_we_o       (ir_we_o),
        .pc_we_o       (pc_we_o),
        .pc_src_o      (pc_src_o),
        .imm_sel_o     (imm_sel_o),
        .alu_src_b_o   (alu_src_b_o),
        .alu_op_o      (alu_op_o),
        .reg_we_o      (reg_we_o),
        .wb_sel_o      (wb_sel_o),
        .busy_o        (busy_o),
        .illegal_o     (illegal_o)
`ifdef MULTICYCLE_CTRL_PERF_EN
        ,
        .cycle_cnt_o   (cycle_cnt_o),
        .instret_o     (instret_o)
`endif
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    // -1 in an expected field means "not specified for this instruction".
    typedef struct {
        int cycles;
        int reg_we;
        int wb_sel;
        int alu_op;
        int src_b;
        int imm_sel;
        int pc_we_exec;
        int pc_src_exec;
        int mem_cycles;
        int memwe_cycles;
    } exp_t;

    typedef struct {
        logic [6:0] op;
        logic [2:0] f3;
        logic       z;
        int         mdelay;
        exp_t       e;
    } vec_t;

    typedef struct {
        int cycles;
        int ir_we;
        int reg_we;
        int wb_sel;
        int alu_op;
        int src_b;
        int imm_sel;
        int pc_we_exec;
        int pc_src_exec;
        int pc_we_cnt;
        int mem_cycles;
        int memwe_cycles;
        int fetch_req;
        int overlap;
        int busy_end;
        int illegal_end;
        int timed_out;
    } obs_t;

    int   checks = 0;
    int   errors = 0;
    vec_t vecs[12];
    exp_t exp_q[$];

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic [6:0] op, input logic [2:0] f3, input logic z,
                                input int md, input int cyc, input int rwe, input int wb,
                                input int alu, input int sb, input int imm, input int pwe,
                                input int psrc, input int mc, input int mwc);
        vec_t v;
        v.op = op; v.f3 = f3; v.z = z; v.mdelay = md;
        v.e.cycles = cyc; v.e.reg_we = rwe; v.e.wb_sel = wb; v.e.alu_op = alu;
        v.e.src_b = sb; v.e.imm_sel = imm; v.e.pc_we_exec = pwe; v.e.pc_src_exec = psrc;
        v.e.mem_cycles = mc; v.e.memwe_cycles = mwc;
        return v;
    endfunction

    // Starts at a negedge with the FSM in FETCH; returns at the negedge of the next FETCH or a non-busy state.
    task automatic run_instr(input logic [6:0] op, input logic [2:0] f3, input logic z,
                             input int fdelay, input int mdelay, input int stop_at,
                             output obs_t o);
        int cyc = 0;
        int wcnt = 0;
        logic [1:0] phase;
        logic [1:0] prev_phase = 2'b00;
        o = '{default: 0};
        opcode_i = op;
        funct3_i = f3;
        zero_i   = z;
        forever begin
            phase = {mem_req_o, mem_addr_sel_o};
            if (cyc > 0 && ((phase == 2'b10 && prev_phase != 2'b10) || !busy_o)) break;
            if (cyc >= 60) begin
                o.timed_out = 1;
                break;
            end
            if (cyc == stop_at) start_i = 1'b0;
            if (phase != prev_phase) wcnt = 0;
            prev_phase = phase;
            if (mem_req_o) begin
                if (wcnt >= (mem_addr_sel_o ? mdelay : fdelay)) begin
                    mem_ready_i = 1'b1;
                    wcnt = 0;
                end else begin
                    mem_ready_i = 1'b0;
                    wcnt++;
                end
            end else begin
                mem_ready_i = 1'b0;
            end
            #1;
            o.ir_we     += int'(ir_we_o);
            o.reg_we    += int'(reg_we_o);
            o.pc_we_cnt += int'(pc_we_o);
            if (cyc == 1) o.imm_sel = int'(imm_sel_o);
            if (cyc == 2) begin
                o.alu_op      = int'(alu_op_o);
                o.src_b       = int'(alu_src_b_o);
                o.pc_we_exec  = int'(pc_we_o);
                o.pc_src_exec = int'(pc_src_o);
            end
            if (reg_we_o) o.wb_sel = int'(wb_sel_o);
            if (mem_req_o && mem_addr_sel_o) o.mem_cycles++;
            if (mem_req_o && mem_we_o) o.memwe_cycles++;
            if (mem_req_o && !mem_addr_sel_o) o.fetch_req++;
            if (ir_we_o && reg_we_o) o.overlap++;
            @(negedge clk_i);
            cyc++;
        end
        mem_ready_i   = 1'b0;
        o.cycles      = cyc;
        o.busy_end    = int'(busy_o);
        o.illegal_end = int'(illegal_o);
    endtask

    task automatic do_reset();
        rst_i       = 1'b0;
        start_i     = 1'b0;
        mem_ready_i = 1'b0;
        #1;
        @(negedge clk_i);
        rst_i   = 1'b1;
        start_i = 1'b1;
        @(negedge clk_i);
    endtask

    initial begin
        obs_t o;
        exp_t e;
        string n;

        vecs[0]  = mk(T_OP_R,      3'b000, 1'b0, 0, 4, 1,  0,  2,  0, -1, 0, -1, 0, 0);
        vecs[1]  = mk(T_OP_I,      3'b000, 1'b0, 0, 4, 1,  0,  2,  1,  0, 0, -1, 0, 0);
        vecs[2]  = mk(T_OP_LOAD,   3'b010, 1'b0, 0, 5, 1,  1,  0,  1,  0, 0, -1, 1, 0);
        vecs[3]  = mk(T_OP_LOAD,   3'b010, 1'b0, 3, 8, 1,  1,  0,  1,  0, 0, -1, 4, 0);
        vecs[4]  = mk(T_OP_STORE,  3'b010, 1'b0, 0, 4, 0, -1,  0,  1,  1, 0, -1, 1, 1);
        vecs[5]  = mk(T_OP_STORE,  3'b010, 1'b0, 2, 6, 0, -1,  0,  1,  1, 0, -1, 3, 3);
        vecs[6]  = mk(T_OP_BRANCH, 3'b000, 1'b1, 0, 3, 0, -1,  1,  0,  2, 1,  1, 0, 0);
        vecs[7]  = mk(T_OP_BRANCH, 3'b000, 1'b0, 0, 3, 0, -1,  1,  0,  2, 0, -1, 0, 0);
        vecs[8]  = mk(T_OP_BRANCH, 3'b001, 1'b0, 0, 3, 0, -1,  1,  0,  2, 1,  1, 0, 0);
        vecs[9]  = mk(T_OP_BRANCH, 3'b001, 1'b1, 0, 3, 0, -1,  1,  0,  2, 0, -1, 0, 0);
        vecs[10] = mk(T_OP_JAL,    3'b000, 1'b0, 0, 4, 1,  2, -1, -1,  4, 1,  1, 0, 0);
        vecs[11] = mk(T_OP_LUI,    3'b000, 1'b0, 0, 4, 1,  3, -1, -1,  3, 0, -1, 0, 0);

        rst_i = 1'b0; start_i = 1'b0; mem_ready_i = 1'b0;
        opcode_i = 7'h00; funct3_i = 3'b000; zero_i = 1'b0;
        repeat (2) @(negedge clk_i);
        #1;
        chk("reset busy", int'(busy_o), 0);
        chk("reset mem_req", int'(mem_req_o), 0);
        chk("reset illegal", int'(illegal_o), 0);
        chk("reset enables", int'(ir_we_o | pc_we_o | reg_we_o), 0);
        @(negedge clk_i);
        rst_i   = 1'b1;
        start_i = 1'b1;
        @(negedge clk_i);

        for (int i = 0; i < 12; i++) begin
            exp_q.push_back(vecs[i].e);
            run_instr(vecs[i].op, vecs[i].f3, vecs[i].z, 0, vecs[i].mdelay, -1, o);
            e = exp_q.pop_front();
            n = $sformatf("v%0d", i);
            chk({n, " timeout"}, o.timed_out, 0);
            chk({n, " cycles"}, o.cycles, e.cycles);
            chk({n, " ir_we"}, o.ir_we, 1);
            chk({n, " fetch_req"}, o.fetch_req, 1);
            chk({n, " reg_we"}, o.reg_we, e.reg_we);
            chk({n, " overlap"}, o.overlap, 0);
            chk({n, " pc_we_cnt"}, o.pc_we_cnt, 1 + e.pc_we_exec);
            chk({n, " pc_we_exec"}, o.pc_we_exec, e.pc_we_exec);
            chk({n, " mem_cycles"}, o.mem_cycles, e.mem_cycles);
            chk({n, " memwe_cycles"}, o.memwe_cycles, e.memwe_cycles);
            if (e.wb_sel >= 0) chk({n, " wb_sel"}, o.wb_sel, e.wb_sel);
            if (e.alu_op >= 0) chk({n, " alu_op"}, o.alu_op, e.alu_op);
            if (e.src_b >= 0) chk({n, " src_b"}, o.src_b, e.src_b);
            if (e.imm_sel >= 0) chk({n, " imm_sel"}, o.imm_sel, e.imm_sel);
            if (e.pc_src_exec >= 0) chk({n, " pc_src"}, o.pc_src_exec, e.pc_src_exec);
        end

        // Unknown opcode traps right after DECODE; TRAP holds every enable low.
        do_reset();
        run_instr(T_OP_BAD, 3'b000, 1'b0, 0, 0, -1, o);
        chk("bad_op cycles", o.cycles, 2);
        chk("bad_op reg_we", o.reg_we, 0);
        chk("bad_op illegal", o.illegal_end, 1);
        chk("bad_op busy", o.busy_end, 0);
        mem_ready_i = 1'b1;
        repeat (3) begin
            #1;
            chk("trap enables", int'(ir_we_o | pc_we_o | reg_we_o | mem_req_o), 0);
            chk("trap illegal", int'(illegal_o), 1);
            @(negedge clk_i);
        end
        mem_ready_i = 1'b0;

        // Branch with an unsupported funct3 traps out of EXEC without a PC write.
        do_reset();
        run_instr(T_OP_BRANCH, 3'b100, 1'b1, 0, 0, -1, o);
        chk("bad_br cycles", o.cycles, 3);
        chk("bad_br pc_we_cnt", o.pc_we_cnt, 1);
        chk("bad_br illegal", o.illegal_end, 1);

        // Fetch never acknowledged: TRAP after 16 waiting cycles, IR never written.
        do_reset();
        chk("pre_tmo illegal", int'(illegal_o), 0);
        run_instr(T_OP_R, 3'b000, 1'b0, NEVER, 0, -1, o);
        chk("fetch_tmo cycles", o.cycles, 16);
        chk("fetch_tmo fetch_req", o.fetch_req, 16);
        chk("fetch_tmo ir_we", o.ir_we, 0);
        chk("fetch_tmo pc_we", o.pc_we_cnt, 0);
        chk("fetch_tmo illegal", o.illegal_end, 1);

        // Load data never acknowledged: 16 MEM_RD cycles then TRAP, no register write.
        do_reset();
        run_instr(T_OP_LOAD, 3'b010, 1'b0, 0, NEVER, -1, o);
        chk("rd_tmo cycles", o.cycles, 19);
        chk("rd_tmo mem_cycles", o.mem_cycles, 16);
        chk("rd_tmo reg_we", o.reg_we, 0);
        chk("rd_tmo illegal", o.illegal_end, 1);

        // Asynchronous reset during a MEM_RD request drops the request without a clock edge.
        do_reset();
        opcode_i = T_OP_LOAD;
        funct3_i = 3'b010;
        mem_ready_i = 1'b1;
        @(negedge clk_i);
        mem_ready_i = 1'b0;
        repeat (2) @(negedge clk_i);
        #1;
        chk("pre_rst mem_req", int'(mem_req_o), 1);
        chk("pre_rst addr_sel", int'(mem_addr_sel_o), 1);
        rst_i   = 1'b0;
        start_i = 1'b0;
        #1;
        chk("async_rst mem_req", int'(mem_req_o), 0);
        chk("async_rst addr_sel", int'(mem_addr_sel_o), 0);
        chk("async_rst busy", int'(busy_o), 0);
        chk("async_rst illegal", int'(illegal_o), 0);
        @(negedge clk_i);
        rst_i = 1'b1;

        // mem_ready_i with no request outstanding does nothing.
        mem_ready_i = 1'b1;
        repeat (3) begin
            @(negedge clk_i);
            #1;
            chk("idle ready busy", int'(busy_o), 0);
            chk("idle ready ir_we", int'(ir_we_o), 0);
        end
        mem_ready_i = 1'b0;

        // start_i dropped in EXEC of SW: the store completes, then the FSM parks in IDLE.
        do_reset();
        run_instr(T_OP_STORE, 3'b010, 1'b0, 0, 0, 2, o);
        chk("stop_sw cycles", o.cycles, 4);
        chk("stop_sw memwe", o.memwe_cycles, 1);
        chk("stop_sw busy", o.busy_end, 0);
        chk("stop_sw illegal", o.illegal_end, 0);
        repeat (3) @(negedge clk_i);
        #1;
        chk("stop_sw idle busy", int'(busy_o), 0);
        chk("stop_sw idle mem_req", int'(mem_req_o), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
